// File: rtl/renode_interrupt_scheduler.sv
// Serialises interrupt-line level changes into a valid/ready message stream, round-robin, with per-line mask.
// Optional RENODE_INTERRUPT_SYNC_EN inserts a 2-flop synchroniser ahead of the level register.
module renode_interrupt_scheduler #(
  parameter int InterruptsCount = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [InterruptsCount-1:0] interrupts,
  input  logic [InterruptsCount-1:0] mask,
  input  logic                       hold,
  output logic                       msg_valid,
  input  logic                       msg_ready,
  output logic [31:0]                msg_addr,
  output logic [63:0]                msg_data,
  output logic                       pending
);

  localparam int IdxW = (InterruptsCount > 1) ? $clog2(InterruptsCount) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(InterruptsCount - 1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StSend = 1'b1;

  logic [InterruptsCount-1:0] sample;
  logic [InterruptsCount-1:0] lvl_q;
  logic [InterruptsCount-1:0] sent_q, sent_d;
  logic [IdxW-1:0]            rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]            addr_q, addr_d;
  logic                       data_q, data_d;
  logic [0:0]                 state_q, state_d;

  logic [InterruptsCount-1:0] grantable;
  logic                       found;
  logic [IdxW-1:0]            grant_idx;
  logic [IdxW-1:0]            cand;
  int                         pos;

`ifdef RENODE_INTERRUPT_SYNC_EN
  logic [InterruptsCount-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= interrupts;
      sync2_q <= sync1_q;
    end
  end

  assign sample = sync2_q;
`else
  assign sample = interrupts;
`endif

  assign grantable = (lvl_q ^ sent_q) & ~mask;
  assign pending   = |grantable;

  // First grantable index at or after rr_ptr, wrapping past the last line.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    pos       = 0;
    for (int k = 0; k < InterruptsCount; k++) begin
      pos = int'(rr_ptr_q) + k;
      if (pos >= InterruptsCount) pos = pos - InterruptsCount;
      cand = IdxW'(pos);
      if (!found && grantable[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    sent_d   = sent_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      StIdle: begin
        if (!hold && found) begin
          addr_d  = grant_idx;
          data_d  = lvl_q[grant_idx];
          state_d = StSend;
        end
      end
      default: begin
        // sent only moves on acceptance, so the in-flight line needs no exclusion from the search.
        if (msg_ready) begin
          sent_d[addr_q] = data_q;
          rr_ptr_d       = (addr_q == LastIdx) ? '0 : addr_q + 1'b1;
          state_d        = StIdle;
        end
      end
    endcase
  end

  // NOTE: state updates use non-blocking assignments so all registers move together on the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      lvl_q    <= '0;
      sent_q   <= '0;
      rr_ptr_q <= '0;
      addr_q   <= '0;
      data_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lvl_q    <= sample;
      sent_q   <= sent_d;
      rr_ptr_q <= rr_ptr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  assign msg_valid = (state_q == StSend);
  assign msg_addr  = {{(32 - IdxW){1'b0}}, addr_q};
  assign msg_data  = {63'd0, data_q};

endmodule

// File: doc/renode_interrupt_scheduler.md
# renode_interrupt_scheduler

Serialises changes on a vector of interrupt lines into a single valid/ready message stream toward the Renode connection, one `renode_pkg::interrupt` message at a time. It sits between the HDL interrupt sources and the shared connection driver. It coalesces repeated toggles, honours a per-line mask and selects between lines round-robin so that no source is starved.

## Interface
Parameters:
- `InterruptsCount`, default 32: number of interrupt lines, 1..256.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `interrupts` in `InterruptsCount`: raw interrupt levels.
- `mask` in `InterruptsCount`: 1 = line suppressed (its changes are held, not sent).
- `hold` in 1: 1 = grant no new message; a message already in flight still completes.
- `msg_valid` out 1: message present.
- `msg_ready` in 1: consumer accepts the message.
- `msg_addr` out 32: line index, `renode_pkg::address_t`.
- `msg_data` out 64: zero-extended level, `renode_pkg::data_t`.
- `pending` out 1: OR of all grantable lines.

## Operation
- `lvl`: registered copy of `interrupts`, sampled every cycle.
- `sent`: per-line last level accepted by the consumer.
- Line i is grantable when `(lvl[i] != sent[i]) && !mask[i]`. Excluding the granted line is not required, because `sent` is only updated on acceptance.
- FSM states:
  - IDLE:
    - If `!hold` and any line is grantable, grant the first grantable index at or after `rr_ptr`, searching upward with wrap.
    - Load `msg_addr` = index and `msg_data` = `lvl[index]`.
    - Go to SEND.
  - SEND:
    - `msg_valid`=1; `msg_addr` and `msg_data` are held stable.
    - On `msg_valid && msg_ready`: `sent[g] <= msg_data`, `rr_ptr <= (g+1) mod InterruptsCount`, go to IDLE.
- Coalescing:
  - A line that toggles an even number of times between acceptances produces no message.
  - An odd number of toggles produces one message carrying the final level.
- If a line changes while its own message is in SEND, the captured value is still sent. The line becomes grantable again after acceptance.
- Mask:
  - Setting mask on a line that is in SEND does not abort that message.
  - Clearing mask sends only the net difference from `sent`.
- `hold` has no effect in SEND.
- No queue exists, so the block has no overflow condition.

## Timing
- Reset values: `msg_valid`=0, `msg_addr`=0, `msg_data`=0, `pending`=0, `lvl`=0, `sent`=0, `rr_ptr`=0, state IDLE.
- Reset asserted in SEND drops the message: `msg_valid`=0 in the cycle after the reset edge.
- Latency: input change before edge k is sampled into `lvl` at edge k, and the grant happens at edge k+1. `msg_valid`=1 after edge k+1, i.e. 2 cycles (4 with `RENODE_INTERRUPT_SYNC_EN`).
- Throughput: at most one message per 2 cycles (SEND then IDLE).
- `msg_valid` deasserts only after acceptance or reset.
- `pending` is combinational from `lvl`, `sent` and `mask`.
- Index wrap: `rr_ptr` returns to 0 after `InterruptsCount-1`.

## Configuration
- `RENODE_INTERRUPT_SYNC_EN`:
  - Defined: a 2-flop synchroniser precedes `lvl` (reset to 0), adding 2 cycles of latency. Used when sources are asynchronous to `clk`.
  - Undefined: `interrupts` is sampled directly into `lvl`.

## Test plan
- Line 3 rises, `msg_ready`=1 (`InterruptsCount`=8) -> `msg_valid` 2 cycles later with `addr`=3, `data`=1, held one cycle; `pending`=0 after acceptance.
- Lines 1, 5 and 6 rise together, `rr_ptr`=6 -> messages in order 6, 1, 5; same lines fall -> order 6, 1, 5 again (ptr=6 after 5).
- Line 2 pulses 1 -> 0 within one cycle while line 4 occupies a stalled SEND (`msg_ready`=0 for 10 cycles) -> no message ever for line 2.
- Line 0 in SEND with `data`=1 falls during stall -> after acceptance a second message `addr`=0, `data`=0.
- Mask line 7, toggle it to 1 -> nothing sent, `pending`=0; unmask -> one message `addr`=7, `data`=1; `hold`=1 during a pending change -> no `msg_valid` until released.
- Assert `rst` while `msg_valid`=1 -> `msg_valid`=0 next cycle; line still high after reset -> fresh message `data`=1.
